// File: rtl/nexys_display_pkg.sv
// rtl/nexys_display_pkg.sv - glyph codes and active-low segment patterns for the Nexys display.
package nexys_display_pkg;

  localparam int GLYPH_DP_BIT = 5;

  localparam logic [5:0] GLYPH_BLANK      = 6'h10;
  localparam logic [5:0] GLYPH_DASH       = 6'h11;
  localparam logic [5:0] GLYPH_UNDERSCORE = 6'h12;
  localparam logic [5:0] GLYPH_H          = 6'h13;
  localparam logic [5:0] GLYPH_L          = 6'h14;
  localparam logic [5:0] GLYPH_N          = 6'h15;
  localparam logic [5:0] GLYPH_O          = 6'h16;
  localparam logic [5:0] GLYPH_P          = 6'h17;
  localparam logic [5:0] GLYPH_R          = 6'h18;
  localparam logic [5:0] GLYPH_T          = 6'h19;
  localparam logic [5:0] GLYPH_U          = 6'h1A;
  localparam logic [5:0] GLYPH_Y          = 6'h1B;
  localparam logic [5:0] GLYPH_S          = 6'h1C;
  localparam logic [5:0] GLYPH_EQUALS     = 6'h1D;
  localparam logic [5:0] GLYPH_I          = 6'h1E;
  localparam logic [5:0] GLYPH_ALL        = 6'h1F;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Bit 0 is segment a (CA) through bit 6 segment g (CG); a 0 lights the segment.
  localparam logic [6:0] SEG_LUT [32] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E,
    7'h7F, 7'h3F, 7'h77, 7'h09, 7'h47, 7'h2B, 7'h23, 7'h0C,
    7'h2F, 7'h07, 7'h41, 7'h11, 7'h12, 7'h37, 7'h7B, 7'h00
  };

endpackage

// File: rtl/sevenseg_glyph.sv
// rtl/sevenseg_glyph.sv - combinational 5-bit glyph code to active-low segment decoder.
module sevenseg_glyph
  import nexys_display_pkg::*;
(
  input  logic [4:0] code_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_LUT[code_i];

endmodule

// File: rtl/sevenseg_scan.sv
// rtl/sevenseg_scan.sv - eight-digit multiplexed seven-segment scanner with frame-latched shadows.
// Optional PWM dimming from brightness when SEVENSEG_DIM_EN is defined.
module sevenseg_scan
  import nexys_display_pkg::*;
#(
  parameter int PRESCALE = 17,
  parameter int BLANK    = 64
) (
  input  logic       clk_peripheral,
  input  logic       peripheral_reset,
  input  logic [5:0] display0,
  input  logic [5:0] display1,
  input  logic [5:0] display2,
  input  logic [5:0] display3,
  input  logic [5:0] display4,
  input  logic [5:0] display5,
  input  logic [5:0] display6,
  input  logic [5:0] display7,
  input  logic [2:0] brightness,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam logic [PRESCALE-1:0] BLANK_CNT = PRESCALE'(BLANK);
  localparam logic [PRESCALE-1:0] CNT_ONE   = PRESCALE'(1);

  logic [PRESCALE-1:0] cnt_q, cnt_d;
  logic [2:0]          idx_q, idx_d;
  logic [5:0]          shadow_q [8];
  logic [5:0]          disp_in  [8];
  logic [5:0]          cur_glyph;
  logic [6:0]          glyph_seg;
  logic                wrap, load, lit;
  logic [7:0]          an_q, an_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;

  assign disp_in[0] = display0;
  assign disp_in[1] = display1;
  assign disp_in[2] = display2;
  assign disp_in[3] = display3;
  assign disp_in[4] = display4;
  assign disp_in[5] = display5;
  assign disp_in[6] = display6;
  assign disp_in[7] = display7;

  assign cur_glyph = shadow_q[idx_q];

  sevenseg_glyph u_glyph (
    .code_i (cur_glyph[4:0]),
    .seg_o  (glyph_seg)
  );

`ifndef SEVENSEG_DIM_EN
  logic unused_brightness;
  assign unused_brightness = ^brightness;
`endif

  always_comb begin
    wrap  = &cnt_q;
    cnt_d = cnt_q + CNT_ONE;
    idx_d = wrap ? idx_q + 3'd1 : idx_q;
    // Latching every shadow as slot 0 begins keeps a whole frame consistent.
    load  = wrap && (idx_q == 3'd7);
    lit   = (cnt_q >= BLANK_CNT);
`ifdef SEVENSEG_DIM_EN
    lit   = lit && (cnt_q[PRESCALE-1 -: 3] <= brightness);
`endif
    an_d  = lit ? ~(8'h80 >> idx_q) : 8'hFF;
    seg_d = lit ? glyph_seg : SEG_OFF;
    dp_d  = lit ? ~cur_glyph[GLYPH_DP_BIT] : 1'b1;
  end

  always_ff @(posedge clk_peripheral) begin
    if (peripheral_reset) begin
      cnt_q <= '0;
      idx_q <= '0;
      for (int i = 0; i < 8; i++) shadow_q[i] <= GLYPH_BLANK;
      an_q  <= 8'hFF;
      seg_q <= SEG_OFF;
      dp_q  <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      if (load) begin
        for (int i = 0; i < 8; i++) shadow_q[i] <= disp_in[i];
      end
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_sevenseg_scan.sv
// tb/tb_sevenseg_scan.sv - randomized bench for sevenseg_scan against a frame/slot reference model.
module tb_sevenseg_scan;

  localparam int PS    = 4;
  localparam int BL    = 2;
  localparam int SLOT  = 1 << PS;
  localparam int FRAME = 8 * SLOT;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] disp [8];
  logic [2:0] bright;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;

  always #5 clk = ~clk;

  sevenseg_scan #(.PRESCALE(PS), .BLANK(BL)) dut (
    .clk_peripheral   (clk),
    .peripheral_reset (rst),
    .display0         (disp[0]),
    .display1         (disp[1]),
    .display2         (disp[2]),
    .display3         (disp[3]),
    .display4         (disp[4]),
    .display5         (disp[5]),
    .display6         (disp[6]),
    .display7         (disp[7]),
    .brightness       (bright),
    .an               (an),
    .seg              (seg),
    .dp               (dp)
  );

  int passed = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
  endtask

  // Lit segments per glyph code, written as segment letters.
  string lit_segs [32] = '{
    "abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
    "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg",
    "", "g", "d", "bcefg", "def", "ceg", "cdeg", "abefg",
    "eg", "defg", "bcdef", "bcdfg", "acdfg", "dg", "c", "abcdefg"
  };

  function automatic logic [6:0] seg_of(input logic [4:0] code);
    logic [6:0] s;
    string      st;
    s  = 7'h7F;
    st = lit_segs[code];
    for (int i = 0; i < st.len(); i++) s[int'(st[i]) - 97] = 1'b0;
    return s;
  endfunction

  int         t;
  int         last_t;
  logic [5:0] shadow [8];
  logic [7:0] exp_an;
  logic [6:0] exp_seg;
  logic       exp_dp;

  task automatic step();
    int  slot, c;
    bit  on;
    @(posedge clk);
    if (rst) begin
      exp_an = 8'hFF; exp_seg = 7'h7F; exp_dp = 1'b1;
      t = 0; last_t = -1;
      for (int i = 0; i < 8; i++) shadow[i] = 6'h10;
    end else begin
      slot = (t / SLOT) % 8;
      c    = t % SLOT;
      on   = (c >= BL);
`ifdef SEVENSEG_DIM_EN
      on   = on && ((c * 8) / SLOT <= int'(bright));
`endif
      if (on) begin
        exp_an  = 8'hFF ^ (8'h01 << (7 - slot));
        exp_seg = seg_of(shadow[slot][4:0]);
        exp_dp  = ~shadow[slot][5];
      end else begin
        exp_an = 8'hFF; exp_seg = 7'h7F; exp_dp = 1'b1;
      end
      last_t = t;
      if (t % FRAME == FRAME - 1) shadow = disp;
      t++;
    end
    #1;
    check("an", an, exp_an);
    check("seg", {1'b0, seg}, {1'b0, exp_seg});
    check("dp", {7'b0, dp}, {7'b0, exp_dp});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst    = 1'b1;
    bright = 3'd7;
    for (int i = 0; i < 8; i++) disp[i] = 6'($urandom_range(0, 63));
    run(5);
    check("reset_an", an, 8'hFF);
    check("reset_seg", {1'b0, seg}, 8'h7F);

    rst     = 1'b0;
    disp[0] = 6'h23;
    disp[3] = 6'h01;
    disp[7] = 6'h0E;
    run(130);
    check("slot0_blank_an", an, 8'hFF);
    run(4);
    check("decode_an", an, 8'h7F);
    check("decode_seg", {1'b0, seg}, 8'h30);
    check("decode_dp", {7'b0, dp}, 8'h00);
    run(112);
    check("hexE_an", an, 8'hFE);
    check("hexE_seg", {1'b0, seg}, 8'h06);
    check("hexE_dp", {7'b0, dp}, 8'h01);

    run(64);
    check("tear_before_seg", {1'b0, seg}, 8'h79);
    run(30);
    disp[3] = 6'h08;
    run(98);
    check("tear_after_an", an, 8'hEF);
    check("tear_after_seg", {1'b0, seg}, 8'h00);

    disp[7] = 6'h10;
    run(192);
    check("blank_glyph_seg", {1'b0, seg}, 8'h7F);

    run(78);
    rst = 1'b1;
    run(1);
    check("midreset_an", an, 8'hFF);
    rst = 1'b0;
    run(3);
    check("restart_an", an, 8'h7F);

`ifdef SEVENSEG_DIM_EN
    bright = 3'd3;
    run(21);
    check("dim3_lit_an", an, 8'hBF);
    run(1);
    check("dim3_dark_an", an, 8'hFF);
    bright = 3'd0;
    run(10);
    check("dim0_dark_an", an, 8'hFF);
`else
    bright = 3'd0;
    run(32);
    check("nodim_lit_an", an, 8'hDF);
`endif
    bright = 3'd7;

    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 19) == 0) disp[$urandom_range(0, 7)] = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 199) == 0) bright = 3'($urandom_range(0, 7));
      rst = ($urandom_range(0, 599) == 0);
      step();
    end
    rst = 1'b0;
    run(FRAME);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
